// File: rtl/audio_i2s_rx_if.sv
// Codec-side pins and parallel sample outputs of the I2S receiver.
// Combinational bundle, no latency of its own.
// No backpressure: samples are strobed out, the consumer must take them on Sample_valid.
interface audio_i2s_rx_if #(
  parameter int DATA_W = 16
);
  logic              AUD_BCLK;
  logic              AUD_ADCLRCK;
  logic              AUD_ADCDAT;
  logic [DATA_W-1:0] Left_out;
  logic [DATA_W-1:0] Right_out;
  logic              Sample_valid;
  logic              Frame_err;

  // Receiver side: takes codec pins, drives samples.
  modport master (
    input  AUD_BCLK, AUD_ADCLRCK, AUD_ADCDAT,
    output Left_out, Right_out, Sample_valid, Frame_err
  );

  // Codec/consumer side: drives codec pins, takes samples.
  modport slave (
    output AUD_BCLK, AUD_ADCLRCK, AUD_ADCDAT,
    input  Left_out, Right_out, Sample_valid, Frame_err
  );
endinterface

// File: rtl/audio_i2s_rx.sv
// I2S ADC receiver: synchronises BCLK/LRCLK/DAT, deserialises MSB-first 16-bit left/right words.
// Latency: pin edge to internal strobe SYNC_STAGES+1 Clk; Sample_valid one Clk after the last right bit strobe.
// No backpressure: outputs hold until the next complete frame. AUDIO_I2S_RX_LJ_EN selects left-justified format.
module audio_i2s_rx #(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic           Clk,
  input  logic           Reset_n,
  audio_i2s_rx_if.master aud
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] bclk_sync;
  logic [SYNC_STAGES-1:0] lrck_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   bclk_s;
  logic                   lrck_s;
  logic                   dat_s;

  logic                   bclk_q;
  logic                   lrck_q;
  logic                   dat_q;
  logic                   bclk_rise;
  logic                   lr_edge;
  logic                   lr_now;
  logic                   lr_fall;

  state_t                 state;
  state_t                 restart_state;
  logic                   chan;
  logic [CNT_W-1:0]       cnt;
  logic [DATA_W-2:0]      shreg;
  logic [DATA_W-1:0]      word_next;
  logic [DATA_W-1:0]      left_hold;
  logic                   left_vld;

  // Equal-depth synchronisers keep DAT aligned with the BCLK it belongs to.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      bclk_sync <= '0;
      lrck_sync <= '0;
      dat_sync  <= '0;
    end else begin
      bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], aud.AUD_BCLK};
      lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], aud.AUD_ADCLRCK};
      dat_sync  <= {dat_sync[SYNC_STAGES-2:0], aud.AUD_ADCDAT};
    end
  end

  assign bclk_s = bclk_sync[SYNC_STAGES-1];
  assign lrck_s = lrck_sync[SYNC_STAGES-1];
  assign dat_s  = dat_sync[SYNC_STAGES-1];

  // Edge register plus registered strobes; DAT gets the same extra flop so it lines up with bclk_rise.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      bclk_q    <= 1'b0;
      lrck_q    <= 1'b0;
      dat_q     <= 1'b0;
      bclk_rise <= 1'b0;
      lr_edge   <= 1'b0;
      lr_now    <= 1'b0;
    end else begin
      bclk_q    <= bclk_s;
      lrck_q    <= lrck_s;
      dat_q     <= dat_s;
      bclk_rise <= bclk_s & ~bclk_q;
      lr_edge   <= lrck_s ^ lrck_q;
      lr_now    <= lrck_s;
    end
  end

  assign lr_fall   = lr_edge & ~lr_now;
  assign word_next = {shreg, dat_q};

`ifdef AUDIO_I2S_RX_LJ_EN
  // Left-justified: MSB arrives on the first BCLK rise after the word-select edge.
  assign restart_state = SHIFT;
`else
  // I2S: one BCLK of delay; a rise coincident with the edge is that delay bit.
  assign restart_state = bclk_rise ? SHIFT : DELAY;
`endif

  // Frame FSM with shift register, left holding register and registered outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state            <= IDLE;
      chan             <= 1'b0;
      cnt              <= '0;
      shreg            <= '0;
      left_hold        <= '0;
      left_vld         <= 1'b0;
      aud.Left_out     <= '0;
      aud.Right_out    <= '0;
      aud.Sample_valid <= 1'b0;
      aud.Frame_err    <= 1'b0;
    end else begin
      aud.Sample_valid <= 1'b0;
      aud.Frame_err    <= 1'b0;
      if (state == IDLE) begin
        // Only a falling word-select edge (start of left) can start a frame.
        if (lr_fall) begin
          state    <= restart_state;
          chan     <= 1'b0;
          cnt      <= '0;
          left_vld <= 1'b0;
        end
      end else if (lr_edge) begin
        // New half-frame; a word still in progress is discarded and flagged.
        if (state != HOLD) begin
          aud.Frame_err <= 1'b1;
        end
        state <= restart_state;
        chan  <= lr_now;
        cnt   <= '0;
        if (!lr_now) begin
          left_vld <= 1'b0;
        end
      end else if (bclk_rise) begin
        case (state)
          DELAY: state <= SHIFT;
          SHIFT: begin
            shreg <= word_next[DATA_W-2:0];
            cnt   <= cnt + 1'b1;
            if (cnt == CNT_W'(DATA_W - 1)) begin
              state <= HOLD;
              if (!chan) begin
                left_hold <= word_next;
                left_vld  <= 1'b1;
              end else if (left_vld) begin
                aud.Left_out     <= left_hold;
                aud.Right_out    <= word_next;
                aud.Sample_valid <= 1'b1;
                left_vld         <= 1'b0;
              end
            end
          end
          default: state <= state;
        endcase
      end
    end
  end

endmodule
